// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one handshaked multiplier between two requesters.
module mul_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_stb,
    output logic             req0_ack,
    output logic [WIDTH-1:0] res0_z,
    output logic             res0_z_stb,
    input  logic             res0_z_ack,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_stb,
    output logic             req1_ack,
    output logic [WIDTH-1:0] res1_z,
    output logic             res1_z_stb,
    input  logic             res1_z_ack,
    output logic [WIDTH-1:0] mul_a,
    output logic             mul_a_stb,
    input  logic             mul_a_ack,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_b_stb,
    input  logic             mul_b_ack,
    input  logic [WIDTH-1:0] mul_z,
    input  logic             mul_z_stb,
    output logic             mul_z_ack,
    output logic             busy,
    output logic             grant
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, PUT_Z} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_z;
    logic             r_grant, r_last, r_a_done, r_b_done;
    logic             w_req, w_sel, w_take;
    // a tie goes to whoever was not served last
    assign w_req      = req0_stb | req1_stb;
    assign w_sel      = req1_stb & (!req0_stb | !r_last);
    assign w_take     = rst & (r_state == IDLE) & w_req;
    assign req0_ack   = w_take & !w_sel;
    assign req1_ack   = w_take & w_sel;
    assign mul_a      = r_a;
    assign mul_b      = r_b;
    assign mul_a_stb  = (r_state == SEND) & !r_a_done;
    assign mul_b_stb  = (r_state == SEND) & !r_b_done;
    assign mul_z_ack  = (r_state == WAIT_Z);
    assign res0_z     = r_z;
    assign res1_z     = r_z;
    assign res0_z_stb = (r_state == PUT_Z) & !r_grant;
    assign res1_z_stb = (r_state == PUT_Z) & r_grant;
    assign busy       = (r_state != IDLE);
    assign grant      = r_grant;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_z      <= '0;
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_grant <= w_sel;
                    r_a     <= w_sel ? req1_a : req0_a;
                    r_b     <= w_sel ? req1_b : req0_b;
                    r_state <= SEND;
                end
                SEND: begin
                    if (mul_a_stb && mul_a_ack) r_a_done <= 1'b1;
                    if (mul_b_stb && mul_b_ack) r_b_done <= 1'b1;
                    // leave one edge after both operands have been taken
                    if (r_a_done && r_b_done) begin
                        r_a_done <= 1'b0;
                        r_b_done <= 1'b0;
                        r_state  <= WAIT_Z;
                    end
                end
                WAIT_Z: if (mul_z_stb) begin
                    r_z     <= mul_z;
                    r_state <= PUT_Z;
                end
                PUT_Z: if (r_grant ? res1_z_ack : res0_z_ack) begin
                    r_last  <= r_grant;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
